// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage: owns the fetch PC, issues pipelined memory
// requests under a credit limit, buffers in-order responses and handles redirects.
module fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr
);

    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam int unsigned     CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] resp_pc_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   drop_cnt_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic [XLEN-1:0] pc_mem_r   [DEPTH];

    logic [CW:0]     occupancy_s;
    logic            req_fire_s;
    logic            resp_accept_s;
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   outstanding_nxt_s;
    logic [CW-1:0]   drop_cnt_nxt_s;
    logic [XLEN-1:0] redirect_target_s;
    logic [1:0]      unused_redirect_lsb_s;

    assign redirect_target_s     = {redirect_addr[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb_s = redirect_addr[1:0];
    assign imem_req_addr         = fetch_pc_r;

    // Credit check and classification of this cycle's request, response and pop.
    always_comb begin
        occupancy_s    = {1'b0, count_r} + {1'b0, outstanding_r};
        imem_req_valid = !rst && !redirect_valid && (occupancy_s < DEPTH_W);
        req_fire_s     = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol violation and is ignored.
        resp_accept_s  = imem_resp_valid && (outstanding_r != {CW{1'b0}});
        push_s         = resp_accept_s && !redirect_valid && (drop_cnt_r == {CW{1'b0}});
        pop_s          = (count_r != {CW{1'b0}}) && instr_ready && !redirect_valid;
    end

    // Next in-flight and stale-response counts.
    always_comb begin
        outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(resp_accept_s);
        if (redirect_valid) begin
            // Every request issued before the redirect cycle is now stale.
            drop_cnt_nxt_s = outstanding_r - CW'(resp_accept_s);
        end else if (resp_accept_s && (drop_cnt_r != {CW{1'b0}})) begin
            drop_cnt_nxt_s = drop_cnt_r - CW'(1'b1);
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Control state: PCs, FIFO pointers and counters; redirect overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r    <= RESET_VECTOR;
            resp_pc_r     <= RESET_VECTOR;
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r    <= redirect_target_s;
            resp_pc_r     <= redirect_target_s;
            count_r       <= {CW{1'b0}};
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
        end else begin
            if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + PC_STEP;
                wr_ptr_r  <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r       <= count_r + CW'(push_s) - CW'(pop_s);
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
        end
    end

    // Prefetch storage; contents are only meaningful below count_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= imem_resp_data;
            pc_mem_r[wr_ptr_r]   <= resp_pc_r;
        end
    end

    // Head presentation, forced to zero while the buffer is empty.
    always_comb begin
        instr_valid = (count_r != {CW{1'b0}});
        if (instr_valid) begin
            instr    = data_mem_r[rd_ptr_r];
            instr_pc = pc_mem_r[rd_ptr_r];
        end else begin
            instr    = {XLEN{1'b0}};
            instr_pc = {XLEN{1'b0}};
        end
    end

    fetch_unit_checker #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_checker (
        .clk             (clk),
        .rst             (rst),
        .imem_resp_valid (imem_resp_valid),
        .outstanding     (outstanding_r),
        .drop_cnt        (drop_cnt_r),
        .fifo_count      (count_r)
    );

endmodule

// Protocol and counter-bound properties for fetch_unit.
module fetch_unit_checker #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          imem_resp_valid,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] drop_cnt,
    input logic [CW-1:0] fifo_count
);

    a_resp_without_request: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (outstanding != {CW{1'b0}}));

    a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
        outstanding <= CW'(DEPTH));

    a_drop_within_outstanding: assert property (@(posedge clk) disable iff (rst)
        drop_cnt <= outstanding);

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, fifo_count} + {1'b0, outstanding}) <= (CW + 1)'(DEPTH));

endmodule
